operand_load_stage: RTL and testbench

- Parametrised successor to the per-port operand-load stage between issue queues and execution units.
- Per issue port it accepts a uop, reads register-file data for NUM_SRC operands, and resolves each operand from one of four sources: small constant, writeback bus, zero-cycle forward, or RF.
- Drives a registered output uop with a one-hot XU enable.
- Adds a 1-entry skid buffer per port with valid/ready backpressure and wrap-aware flushing of both stage entries.

---
 rtl/operand_load_stage.sv | 178 +++++++++++++++++
 tb/tb_operand_load_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_load_stage.sv
// Per-port operand-load stage: resolves source operands at accept, then holds them
// in an output register backed by a 1-entry skid buffer with wrap-aware flushing.
module operand_load_stage #(
  parameter  int NUM_PORTS = 4,
  parameter  int NUM_SRC   = 2,
  parameter  int XLEN      = 32,
  parameter  int TAG_W     = 7,
  parameter  int SQN_W     = 7,
  parameter  int NUM_WBS   = 4,
  parameter  int NUM_ZC    = 2,
  parameter  int NUM_XUS   = 7,
  parameter  int PAY_W     = 64,
  localparam int FU_W      = (NUM_XUS > 1) ? $clog2(NUM_XUS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  IN_valid,
  output logic [NUM_PORTS-1:0]                  OUT_ready,
  input  logic [NUM_PORTS*SQN_W-1:0]            IN_sqN,
  input  logic [NUM_PORTS*NUM_SRC*TAG_W-1:0]    IN_srcTag,
  input  logic [NUM_PORTS-1:0]                  IN_useImm,
  input  logic [NUM_PORTS*XLEN-1:0]             IN_imm,
  input  logic [NUM_PORTS*FU_W-1:0]             IN_fu,
  input  logic [NUM_PORTS*PAY_W-1:0]            IN_payload,
  output logic [NUM_PORTS*NUM_SRC*(TAG_W-1)-1:0] OUT_rfReadAddr,
  input  logic [NUM_PORTS*NUM_SRC*XLEN-1:0]     IN_rfReadData,
  input  logic [NUM_WBS-1:0]                    IN_wbValid,
  input  logic [NUM_WBS*TAG_W-1:0]              IN_wbTag,
  input  logic [NUM_WBS*XLEN-1:0]               IN_wbData,
  input  logic [NUM_ZC-1:0]                     IN_zcValid,
  input  logic [NUM_ZC*TAG_W-1:0]               IN_zcTag,
  input  logic [NUM_ZC*XLEN-1:0]                IN_zcData,
  input  logic                                  IN_invalidate,
  input  logic [SQN_W-1:0]                      IN_invalidateSqN,
  input  logic [NUM_PORTS-1:0]                  IN_stall,
  output logic [NUM_PORTS-1:0]                  OUT_valid,
  output logic [NUM_PORTS*SQN_W-1:0]            OUT_sqN,
  output logic [NUM_PORTS*NUM_SRC*XLEN-1:0]     OUT_srcData,
  output logic [NUM_PORTS*PAY_W-1:0]            OUT_payload,
  output logic [NUM_PORTS*FU_W-1:0]             OUT_fu,
  output logic [NUM_PORTS*NUM_XUS-1:0]          OUT_enableXU
);

  logic [NUM_PORTS-1:0][SQN_W-1:0]               w_in_sqn;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][TAG_W-1:0]  w_in_tag;
  logic [NUM_PORTS-1:0][XLEN-1:0]                w_in_imm;
  logic [NUM_PORTS-1:0][FU_W-1:0]                w_in_fu;
  logic [NUM_PORTS-1:0][PAY_W-1:0]               w_in_pay;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][XLEN-1:0]   w_rf;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][XLEN-1:0]   w_res;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][TAG_W-2:0]  w_rf_addr;
  logic [NUM_WBS-1:0][TAG_W-1:0]                 w_wb_tag;
  logic [NUM_WBS-1:0][XLEN-1:0]                  w_wb_data;
  logic [NUM_ZC-1:0][TAG_W-1:0]                  w_zc_tag;
  logic [NUM_ZC-1:0][XLEN-1:0]                   w_zc_data;
  logic [NUM_PORTS-1:0][NUM_XUS-1:0]             w_en;
  logic [NUM_PORTS-1:0] w_accept, w_advance, w_out_live, w_skid_live;

  logic [NUM_PORTS-1:0]                          r_out_valid, r_skid_valid;
  logic [NUM_PORTS-1:0][SQN_W-1:0]               r_out_sqn, r_skid_sqn;
  logic [NUM_PORTS-1:0][NUM_SRC-1:0][XLEN-1:0]   r_out_src, r_skid_src;
  logic [NUM_PORTS-1:0][FU_W-1:0]                r_out_fu, r_skid_fu;
  logic [NUM_PORTS-1:0][PAY_W-1:0]               r_out_pay, r_skid_pay;

  assign w_in_sqn  = IN_sqN;
  assign w_in_tag  = IN_srcTag;
  assign w_in_imm  = IN_imm;
  assign w_in_fu   = IN_fu;
  assign w_in_pay  = IN_payload;
  assign w_rf      = IN_rfReadData;
  assign w_wb_tag  = IN_wbTag;
  assign w_wb_data = IN_wbData;
  assign w_zc_tag  = IN_zcTag;
  assign w_zc_data = IN_zcData;

  // Sequence numbers wrap, so "younger" is the sign of the modular difference.
  function automatic logic younger(input logic [SQN_W-1:0] s, input logic [SQN_W-1:0] base);
    logic [SQN_W-1:0] d;
    d = s - base;
    return (d != '0) && !d[SQN_W-1];
  endfunction

  always_comb begin
    w_res     = '0;
    w_rf_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        w_rf_addr[p][s] = w_in_tag[p][s][TAG_W-2:0];
        w_res[p][s]     = w_rf[p][s];
        for (int w = 0; w < NUM_WBS; w++)
          if (IN_wbValid[w] && (w_wb_tag[w] == w_in_tag[p][s])) w_res[p][s] = w_wb_data[w];
        for (int z = 0; z < NUM_ZC; z++)
          if (IN_zcValid[z] && (w_zc_tag[z] == w_in_tag[p][s])) w_res[p][s] = w_zc_data[z];
        if (w_in_tag[p][s][TAG_W-1])
          w_res[p][s] = {{(XLEN-TAG_W+1){w_in_tag[p][s][TAG_W-2]}}, w_in_tag[p][s][TAG_W-2:0]};
        if ((s == 1) && IN_useImm[p]) w_res[p][s] = w_in_imm[p];
      end
    end
  end

  always_comb begin
    w_out_live  = '0;
    w_skid_live = '0;
    w_accept    = '0;
    w_advance   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_out_live[p]  = r_out_valid[p] && !(IN_invalidate && younger(r_out_sqn[p], IN_invalidateSqN));
      w_skid_live[p] = r_skid_valid[p] && !(IN_invalidate && younger(r_skid_sqn[p], IN_invalidateSqN));
      w_accept[p]    = IN_valid[p] && !r_skid_valid[p] &&
                       !(IN_invalidate && younger(w_in_sqn[p], IN_invalidateSqN));
      w_advance[p]   = !IN_stall[p] || !w_out_live[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= '0;
      r_skid_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_advance[p]) begin
          r_out_valid[p]  <= w_skid_live[p] || w_accept[p];
          r_skid_valid[p] <= 1'b0;
        end else begin
          r_out_valid[p]  <= w_out_live[p];
          r_skid_valid[p] <= w_skid_live[p] || w_accept[p];
        end
      end
    end
  end

  // Payload registers carry no reset; only the valid bits above qualify them.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_advance[p]) begin
        if (r_skid_valid[p]) begin
          r_out_sqn[p] <= r_skid_sqn[p];
          r_out_src[p] <= r_skid_src[p];
          r_out_fu[p]  <= r_skid_fu[p];
          r_out_pay[p] <= r_skid_pay[p];
        end else begin
          r_out_sqn[p] <= w_in_sqn[p];
          r_out_src[p] <= w_res[p];
          r_out_fu[p]  <= w_in_fu[p];
          r_out_pay[p] <= w_in_pay[p];
        end
      end else if (w_accept[p]) begin
        r_skid_sqn[p] <= w_in_sqn[p];
        r_skid_src[p] <= w_res[p];
        r_skid_fu[p]  <= w_in_fu[p];
        r_skid_pay[p] <= w_in_pay[p];
      end
    end
  end

  always_comb begin
    w_en = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (r_out_valid[p] && ({1'b0, r_out_fu[p]} < (FU_W+1)'(NUM_XUS)))
        w_en[p][r_out_fu[p]] = 1'b1;
  end

  assign OUT_ready      = ~r_skid_valid;
  assign OUT_valid      = r_out_valid;
  assign OUT_sqN        = r_out_sqn;
  assign OUT_srcData    = r_out_src;
  assign OUT_fu         = r_out_fu;
  assign OUT_payload    = r_out_pay;
  assign OUT_enableXU   = w_en;
  assign OUT_rfReadAddr = w_rf_addr;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fu_chk
    // An out-of-range FU code leaves the uop valid but enables no unit.
    a_fu_range: assert property (@(posedge clk) disable iff (rst)
      r_out_valid[g] |-> ({1'b0, r_out_fu[g]} < (FU_W+1)'(NUM_XUS)));
  end

endmodule

// File: tb/tb_operand_load_stage.sv
// Directed bench for operand_load_stage: a vector table for operand resolution on
// port 0, then hand-written backpressure, flush and async-reset sequences.
module tb_operand_load_stage;
  localparam int NP = 4, NS = 2, XL = 32, TW = 7, SW = 7, NW = 4, NZ = 2, NX = 7, PW = 64, FW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NP-1:0]                 in_valid, out_ready, in_use_imm, in_stall, out_valid;
  logic [NP-1:0][SW-1:0]         in_sqn, out_sqn;
  logic [NP-1:0][NS-1:0][TW-1:0] in_tag;
  logic [NP-1:0][XL-1:0]         in_imm;
  logic [NP-1:0][FW-1:0]         in_fu, out_fu;
  logic [NP-1:0][PW-1:0]         in_pay, out_pay;
  logic [NP-1:0][NS-1:0][TW-2:0] rf_addr;
  logic [NP-1:0][NS-1:0][XL-1:0] rf_data, out_src;
  logic [NW-1:0]                 wb_valid;
  logic [NW-1:0][TW-1:0]         wb_tag;
  logic [NW-1:0][XL-1:0]         wb_data;
  logic [NZ-1:0]                 zc_valid;
  logic [NZ-1:0][TW-1:0]         zc_tag;
  logic [NZ-1:0][XL-1:0]         zc_data;
  logic                          inv;
  logic [SW-1:0]                 inv_sqn;
  logic [NP-1:0][NX-1:0]         out_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_load_stage dut (
    .clk(clk), .rst(rst),
    .IN_valid(in_valid), .OUT_ready(out_ready), .IN_sqN(in_sqn), .IN_srcTag(in_tag),
    .IN_useImm(in_use_imm), .IN_imm(in_imm), .IN_fu(in_fu), .IN_payload(in_pay),
    .OUT_rfReadAddr(rf_addr), .IN_rfReadData(rf_data),
    .IN_wbValid(wb_valid), .IN_wbTag(wb_tag), .IN_wbData(wb_data),
    .IN_zcValid(zc_valid), .IN_zcTag(zc_tag), .IN_zcData(zc_data),
    .IN_invalidate(inv), .IN_invalidateSqN(inv_sqn), .IN_stall(in_stall),
    .OUT_valid(out_valid), .OUT_sqN(out_sqn), .OUT_srcData(out_src),
    .OUT_payload(out_pay), .OUT_fu(out_fu), .OUT_enableXU(out_en)
  );

  typedef struct {
    logic [TW-1:0] t0, t1;
    logic          use_imm;
    logic [XL-1:0] imm;
    logic [FW-1:0] fu;
    logic [NW-1:0] wbv;
    logic [NZ-1:0] zcv;
    logic [XL-1:0] e0, e1;
    logic [NX-1:0] e_en;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive0(input logic [SW-1:0] sq, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                        input logic ui, input logic [XL-1:0] imm, input logic [FW-1:0] fu);
    in_valid[0]   = 1'b1;
    in_sqn[0]     = sq;
    in_tag[0][0]  = t0;
    in_tag[0][1]  = t1;
    in_use_imm[0] = ui;
    in_imm[0]     = imm;
    in_fu[0]      = fu;
    in_pay[0]     = {32'hC0DE0000, 25'd0, sq};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{7'h05, 7'h06, 1'b0, 32'h0,        3'd2, 4'h0, 2'h0, 32'h11,       32'h22,       7'b0000100};
    vecs[1]  = '{7'h05, 7'h06, 1'b0, 32'h0,        3'd1, 4'hF, 2'h3, 32'hCCCC,     32'h6666,     7'b0000010};
    vecs[2]  = '{7'h05, 7'h06, 1'b0, 32'h0,        3'd3, 4'hF, 2'h0, 32'hBBBB,     32'h6666,     7'b0001000};
    vecs[3]  = '{7'h05, 7'h06, 1'b0, 32'h0,        3'd0, 4'h1, 2'h0, 32'hAAAA,     32'h22,       7'b0000001};
    vecs[4]  = '{7'h05, 7'h06, 1'b0, 32'h0,        3'd4, 4'hF, 2'h1, 32'hD0D0,     32'h6666,     7'b0010000};
    vecs[5]  = '{7'h7E, 7'h06, 1'b0, 32'h0,        3'd6, 4'h0, 2'h0, 32'hFFFFFFFE, 32'h22,       7'b1000000};
    vecs[6]  = '{7'h05, 7'h7E, 1'b1, 32'h1234,     3'd5, 4'h0, 2'h0, 32'h11,       32'h1234,     7'b0100000};
    vecs[7]  = '{7'h41, 7'h5F, 1'b0, 32'h0,        3'd0, 4'hF, 2'h3, 32'h1,        32'h1F,       7'b0000001};
    vecs[8]  = '{7'h05, 7'h05, 1'b1, 32'hDEADBEEF, 3'd2, 4'hF, 2'h3, 32'hCCCC,     32'hDEADBEEF, 7'b0000100};
    vecs[9]  = '{7'h45, 7'h06, 1'b0, 32'h0,        3'd1, 4'hF, 2'h0, 32'h5,        32'h6666,     7'b0000010};
    vecs[10] = '{7'h10, 7'h10, 1'b0, 32'h0,        3'd2, 4'h2, 2'h0, 32'h1010,     32'h1010,     7'b0000100};

    in_valid = '0; in_use_imm = '0; in_stall = '0; in_sqn = '0; in_tag = '0;
    in_imm = '0; in_fu = '0; in_pay = '0; inv = 1'b0; inv_sqn = '0;
    rf_data[0][0] = 32'h11; rf_data[0][1] = 32'h22;
    rf_data[1][0] = 32'h33; rf_data[1][1] = 32'h44;
    rf_data[2][0] = 32'h55; rf_data[2][1] = 32'h66;
    rf_data[3][0] = 32'h77; rf_data[3][1] = 32'h88;
    wb_valid = '0; zc_valid = '0;
    wb_tag[0] = 7'h05; wb_data[0] = 32'hAAAA;
    wb_tag[1] = 7'h10; wb_data[1] = 32'h1010;
    wb_tag[2] = 7'h06; wb_data[2] = 32'h6666;
    wb_tag[3] = 7'h05; wb_data[3] = 32'hBBBB;
    zc_tag[0] = 7'h05; zc_data[0] = 32'hD0D0;
    zc_tag[1] = 7'h05; zc_data[1] = 32'hCCCC;

    #1 rst = 1'b1;
    #2;
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_en", 64'(out_en), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_ready", 64'(out_ready), 64'hF);

    // Operand resolution table, one uop per cycle on port 0
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive0(SW'(i + 32), vecs[i].t0, vecs[i].t1, vecs[i].use_imm, vecs[i].imm, vecs[i].fu);
      wb_valid = vecs[i].wbv;
      zc_valid = vecs[i].zcv;
      #1;
      check($sformatf("v%0d_rfaddr", i), 64'({rf_addr[0][1], rf_addr[0][0]}),
            64'({vecs[i].t1[5:0], vecs[i].t0[5:0]}));
      tick();
      check($sformatf("v%0d_valid", i), 64'(out_valid[0]), 64'h1);
      check($sformatf("v%0d_src0", i), 64'(out_src[0][0]), 64'(vecs[i].e0));
      check($sformatf("v%0d_src1", i), 64'(out_src[0][1]), 64'(vecs[i].e1));
      check($sformatf("v%0d_en", i), 64'(out_en[0]), 64'(vecs[i].e_en));
      check($sformatf("v%0d_sqn", i), 64'(out_sqn[0]), 64'(i + 32));
      check($sformatf("v%0d_pay", i), out_pay[0], {32'hC0DE0000, 32'(i + 32)});
    end
    @(negedge clk);
    in_valid = '0; wb_valid = '0; zc_valid = '0;
    tick();
    check("drain_valid", 64'(out_valid[0]), 64'h0);
    check("drain_en", 64'(out_en[0]), 64'h0);

    // Backpressure: A held in output, B in skid, C held off
    @(negedge clk);
    drive0(7'd3, 7'h05, 7'h06, 1'b0, 32'h0, 3'd2);
    tick();
    check("bp_a_sqn", 64'(out_sqn[0]), 64'd3);
    @(negedge clk);
    in_stall[0] = 1'b1;
    drive0(7'd4, 7'h7E, 7'h06, 1'b0, 32'h0, 3'd5);
    in_valid[2] = 1'b1; in_sqn[2] = 7'h22; in_tag[2][0] = 7'h05; in_tag[2][1] = 7'h06; in_fu[2] = 3'd0;
    tick();
    check("bp_hold_sqn", 64'(out_sqn[0]), 64'd3);
    check("bp_ready0", 64'(out_ready[0]), 64'h0);
    check("bp_ready2", 64'(out_ready[2]), 64'h1);
    check("p2_valid", 64'(out_valid[2]), 64'h1);
    check("p2_sqn", 64'(out_sqn[2]), 64'h22);
    check("p2_src0", 64'(out_src[2][0]), 64'h55);
    @(negedge clk);
    drive0(7'd5, 7'h05, 7'h06, 1'b0, 32'h0, 3'd3);
    wb_valid = 4'hF;
    in_valid[2] = 1'b0;
    tick();
    check("bp_c_held_sqn", 64'(out_sqn[0]), 64'd3);
    check("bp_c_held_ready", 64'(out_ready[0]), 64'h0);
    @(negedge clk);
    in_stall[0] = 1'b0;
    tick();
    check("bp_b_sqn", 64'(out_sqn[0]), 64'd4);
    check("bp_b_src0", 64'(out_src[0][0]), 64'hFFFFFFFE);
    check("bp_b_src1", 64'(out_src[0][1]), 64'h22);
    check("bp_b_en", 64'(out_en[0]), 64'b0100000);
    check("bp_b_ready", 64'(out_ready[0]), 64'h1);
    tick();
    check("bp_c_sqn", 64'(out_sqn[0]), 64'd5);
    check("bp_c_src1", 64'(out_src[0][1]), 64'h6666);
    @(negedge clk);
    in_valid = '0; wb_valid = '0;
    tick();
    check("bp_end_valid", 64'(out_valid[0]), 64'h0);

    // Wrap-aware flush of both entries while stalled
    @(negedge clk);
    drive0(7'h7F, 7'h05, 7'h06, 1'b0, 32'h0, 3'd2);
    tick();
    @(negedge clk);
    in_stall[0] = 1'b1;
    drive0(7'h01, 7'h05, 7'h06, 1'b0, 32'h0, 3'd2);
    tick();
    check("wrap_full_ready", 64'(out_ready[0]), 64'h0);
    @(negedge clk);
    in_valid = '0; inv = 1'b1; inv_sqn = 7'h01;
    tick();
    check("wrap_keep_valid", 64'(out_valid[0]), 64'h1);
    check("wrap_keep_sqn", 64'(out_sqn[0]), 64'h7F);
    check("wrap_keep_ready", 64'(out_ready[0]), 64'h0);
    check("wrap_keep_en", 64'(out_en[0]), 64'b0000100);
    @(negedge clk);
    inv_sqn = 7'h7E;
    tick();
    check("wrap_kill_valid", 64'(out_valid[0]), 64'h0);
    check("wrap_kill_en", 64'(out_en[0]), 64'h0);
    check("wrap_kill_ready", 64'(out_ready[0]), 64'h1);
    @(negedge clk);
    inv = 1'b0; in_stall[0] = 1'b0;
    tick();
    check("wrap_after_valid", 64'(out_valid[0]), 64'h0);

    // Skid entry killed in the same cycle the output advances
    @(negedge clk);
    drive0(7'h10, 7'h05, 7'h06, 1'b0, 32'h0, 3'd1);
    tick();
    @(negedge clk);
    in_stall[0] = 1'b1;
    drive0(7'h30, 7'h05, 7'h06, 1'b0, 32'h0, 3'd1);
    tick();
    @(negedge clk);
    in_valid = '0; in_stall[0] = 1'b0; inv = 1'b1; inv_sqn = 7'h20;
    tick();
    check("prio_valid", 64'(out_valid[0]), 64'h0);
    check("prio_ready", 64'(out_ready[0]), 64'h1);
    @(negedge clk);
    inv = 1'b0;
    tick();
    check("prio_after_valid", 64'(out_valid[0]), 64'h0);

    // Kill at accept: younger input refused, older accepted
    @(negedge clk);
    inv = 1'b1; inv_sqn = 7'h10;
    drive0(7'h20, 7'h05, 7'h06, 1'b0, 32'h0, 3'd0);
    tick();
    check("acc_kill_valid", 64'(out_valid[0]), 64'h0);
    @(negedge clk);
    drive0(7'h08, 7'h05, 7'h06, 1'b0, 32'h0, 3'd0);
    tick();
    check("acc_old_valid", 64'(out_valid[0]), 64'h1);
    check("acc_old_sqn", 64'(out_sqn[0]), 64'h08);
    @(negedge clk);
    in_valid = '0; inv = 1'b0;
    tick();

    // Async reset between edges while output and skid are full
    @(negedge clk);
    drive0(7'd3, 7'h05, 7'h06, 1'b0, 32'h0, 3'd2);
    tick();
    @(negedge clk);
    in_stall[0] = 1'b1;
    drive0(7'd4, 7'h05, 7'h06, 1'b0, 32'h0, 3'd2);
    tick();
    check("ar_pre_ready", 64'(out_ready[0]), 64'h0);
    @(negedge clk);
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'h0);
    check("ar_ready", 64'(out_ready), 64'hF);
    check("ar_en", 64'(out_en), 64'h0);
    @(negedge clk);
    rst = 1'b0; in_stall = '0;
    tick();
    check("ar_after_valid", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
